// File: rtl/boa_uart_bus_bridge.sv
// boa_uart_bus_bridge: turns UART byte commands into single 32-bit bus transactions
//   clk, rst                      clock, synchronous active-high reset
//   rx_data, rx_valid, rx_ready   command bytes from the receive FIFO
//   tx_data, tx_valid, tx_ready   response bytes to the transmit FIFO
//   addr, we, re, wdata           bus request (addr word-aligned)
//   rdata, ready                  bus response and completion flag
//   busy                          high whenever the bridge is not idle
module boa_uart_bus_bridge #(
    parameter int TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] addr,
    output logic [3:0]  we,
    output logic        re,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        ready,
    output logic        busy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;
    state_t        r_state;
    logic [1:0]    r_idx;
    logic [1:0]    r_last;
    logic          r_wr;
    logic          r_first;
    logic [31:0]   r_resp;
    logic [CW-1:0] r_idle;
    logic          w_rx_fire;
    logic          w_timeout;
    logic [1:0]    w_nidx;
    // bytes are only taken while a command is being collected; otherwise they wait upstream
    assign rx_ready  = r_state inside {IDLE, ADDR, DATA};
    assign busy      = r_state != IDLE;
    assign w_rx_fire = rx_valid && rx_ready;
    assign w_timeout = !w_rx_fire && r_idle == CW'(TIMEOUT - 1);
    assign w_nidx    = r_idx + 2'd1;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_last   <= '0;
            r_wr     <= 1'b0;
            r_first  <= 1'b0;
            r_resp   <= '0;
            r_idle   <= '0;
            addr     <= '0;
            wdata    <= '0;
            we       <= '0;
            re       <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            r_idle <= '0;
            case (r_state)
                IDLE: begin
                    r_idx  <= '0;
                    r_last <= '0;
                    if (w_rx_fire) begin
                        r_wr <= rx_data == 8'h57;
                        if (rx_data == 8'h57 || rx_data == 8'h52) r_state <= ADDR;
                        else begin
                            r_state  <= RESP;
                            tx_valid <= 1'b1;
                            tx_data  <= rx_data == 8'h3F ? 8'hB0 : 8'h15;
                        end
                    end
                end
                ADDR, DATA: begin
                    if (w_rx_fire) begin
                        r_idx <= w_nidx;
                        // little-endian assembly; address is forced word-aligned as it arrives
                        if (r_state == ADDR) addr[{r_idx, 3'b000} +: 8] <= r_idx == 2'd0 ? {rx_data[7:2], 2'b00} : rx_data;
                        else wdata[{r_idx, 3'b000} +: 8] <= rx_data;
                        if (r_idx == 2'd3 && r_state == ADDR && r_wr) r_state <= DATA;
                        else if (r_idx == 2'd3) begin
                            r_state <= BUS;
                            we      <= {4{r_wr}};
                            re      <= !r_wr;
                            r_first <= 1'b1;
                        end
                    end else if (w_timeout) r_state <= IDLE;
                    else r_idle <= r_idle + 1'b1;
                end
                BUS: begin
                    // ready seen in the first request cycle belongs to nobody and is ignored
                    r_first <= 1'b0;
                    if (ready && !r_first) begin
                        r_state  <= RESP;
                        we       <= '0;
                        re       <= 1'b0;
                        r_resp   <= rdata;
                        r_last   <= r_wr ? 2'd0 : 2'd3;
                        tx_valid <= 1'b1;
                        tx_data  <= r_wr ? 8'h06 : rdata[7:0];
                    end
                end
                RESP: begin
                    if (tx_ready) begin
                        if (r_idx == r_last) begin
                            r_state  <= IDLE;
                            tx_valid <= 1'b0;
                        end else begin
                            r_idx   <= w_nidx;
                            tx_data <= r_resp[{w_nidx, 3'b000} +: 8];
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_boa_uart_bus_bridge.sv
// tb_boa_uart_bus_bridge: scoreboard bench for the UART-to-bus bridge
module tb_boa_uart_bus_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [31:0] addr;
    logic [3:0]  we;
    logic        re;
    logic [31:0] wdata;
    logic [31:0] rdata = '0;
    logic        ready = 1'b0;
    logic        busy;

    boa_uart_bus_bridge #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .addr(addr), .we(we), .re(re), .wdata(wdata),
        .rdata(rdata), .ready(ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
    } bus_t;

    logic [7:0]  rx_q[$];
    logic [7:0]  tx_exp[$];
    bus_t        bus_exp[$];
    logic [31:0] rd_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int tx_mode = 0;
    int rdy_mode = 1;
    int rdy_wait = 0;
    int gap_max = 0;
    int gap = 0;
    int bus_cnt = 0;
    logic rx_fire = 1'b0;
    logic prev_re = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // upstream FIFO, transmit sink and bus responder
    always @(negedge clk) rx_fire = rx_valid && rx_ready;
    always @(posedge clk) begin
        #1;
        if (rx_fire) begin
            void'(rx_q.pop_front());
            gap = $urandom_range(0, gap_max);
        end
        if (prev_re && !re && rd_q.size() > 0) void'(rd_q.pop_front());
        prev_re = re;
        if (gap > 0) begin
            gap--;
            rx_valid = 1'b0;
        end else rx_valid = !rst && rx_q.size() > 0;
        rx_data = rx_q.size() > 0 ? rx_q[0] : 8'h00;
        tx_ready = tx_mode == 0 ? 1'b1 : tx_mode == 1 ? 1'($urandom_range(0, 1)) : !tx_ready;
        bus_cnt = (re || we != 4'h0) ? bus_cnt + 1 : 0;
        ready = rdy_mode == 0 ? 1'($urandom_range(0, 1)) : rdy_mode == 1 ? bus_cnt > rdy_wait : 1'b0;
        rdata = rd_q.size() > 0 ? rd_q[0] : 32'h0;
    end

    // monitor: compares whatever the DUT presents against the expectation queues
    logic        m_req = 1'b0, m_fire = 1'b0, m_rst = 1'b1, m_start = 1'b0, m_hold = 1'b0;
    logic [7:0]  m_tx = '0;
    logic [31:0] m_a = '0, m_d = '0;
    always @(negedge clk) begin
        logic req;
        bus_t e;
        req = re || we != 4'h0;
        if (!rst) begin
            if (tx_valid && m_hold) chk("tx_hold", tx_data, m_tx);
            if (tx_valid && tx_ready) begin
                if (tx_exp.size() == 0) chk("tx_unexpected", 1, 0);
                else chk("tx_byte", tx_data, tx_exp.pop_front());
            end
            if (req && !m_req) begin
                chk("cmd_to_req_latency", m_fire, 1);
                chk("re_we_exclusive", {re, we}, re ? 5'b10000 : 5'b01111);
                if (bus_exp.size() == 0) chk("bus_unexpected", 1, 0);
                else begin
                    e = bus_exp.pop_front();
                    chk("bus_kind_re", re, !e.wr);
                    chk("bus_addr", addr, e.a);
                    if (e.wr) chk("bus_wdata", wdata, e.d);
                end
                m_a = addr;
                m_d = wdata;
            end
            if (req && m_req) chk("bus_hold", {addr, wdata}, {m_a, m_d});
            if (m_start && !m_rst) chk("first_ready_ignored", req, 1);
            if (!req && m_req && !m_rst) chk("done_to_tx_latency", tx_valid, 1);
        end
        m_hold  = tx_valid && !tx_ready;
        m_tx    = tx_data;
        m_start = req && !m_req;
        m_req   = req;
        m_fire  = rx_valid && rx_ready;
        m_rst   = rst;
    end

    // reference model: commands expand into byte streams and expected responses
    task automatic send_write(input logic [31:0] a, input logic [31:0] d);
        rx_q.push_back(8'h57);
        for (int i = 0; i < 4; i++) rx_q.push_back(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) rx_q.push_back(d[8*i +: 8]);
        bus_exp.push_back('{1'b1, {a[31:2], 2'b00}, d});
        tx_exp.push_back(8'h06);
    endtask

    task automatic send_read(input logic [31:0] a, input logic [31:0] r);
        rx_q.push_back(8'h52);
        for (int i = 0; i < 4; i++) rx_q.push_back(a[8*i +: 8]);
        bus_exp.push_back('{1'b0, {a[31:2], 2'b00}, 32'h0});
        rd_q.push_back(r);
        for (int i = 0; i < 4; i++) tx_exp.push_back(r[8*i +: 8]);
    endtask

    task automatic send_other(input logic [7:0] b);
        rx_q.push_back(b);
        tx_exp.push_back(b == 8'h3F ? 8'hB0 : 8'h15);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((rx_q.size() > 0 || tx_exp.size() > 0 || bus_exp.size() > 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, n < 3000, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_we", we, 0);
        chk("rst_re", re, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;

        send_write(32'h80000010, 32'hDEADBEEF);
        drain("write_done");

        rdy_wait = 5;
        send_read(32'h80000007, 32'h12345678);
        drain("read_wait_done");

        tx_mode = 2;
        rdy_wait = 2;
        send_read(32'h00000100, $urandom);
        drain("backpressure_done");

        tx_mode = 0;
        send_other(8'h41);
        send_other(8'h3F);
        drain("probe_nak_done");

        rx_q.push_back(8'h57);
        rx_q.push_back(8'h01);
        rx_q.push_back(8'h02);
        drain("timeout_drop");
        repeat (4) @(negedge clk);
        send_read(32'h0, $urandom);
        drain("after_timeout_read");

        rdy_mode = 2;
        rx_q.push_back(8'h52);
        rx_q.push_back(8'h40);
        for (int i = 0; i < 3; i++) rx_q.push_back(8'h00);
        bus_exp.push_back('{1'b0, 32'h40, 32'h0});
        n = 0;
        while (!re && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_bus_re_seen", re, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_bus_rst_re", re, 0);
        chk("mid_bus_rst_busy", busy, 0);
        chk("mid_bus_rst_rx_ready", rx_ready, 1);
        rdy_mode = 1;
        send_other(8'h3F);
        drain("after_reset_probe");

        gap_max = 3;
        tx_mode = 1;
        rdy_mode = 0;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: send_write($urandom, $urandom);
                1: send_read($urandom, $urandom);
                2: send_other(8'h3F);
                default: begin
                    do b = 8'($urandom); while (b == 8'h57 || b == 8'h52 || b == 8'h3F);
                    send_other(b);
                end
            endcase
        end
        drain("random_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
